// File: rtl/adc_trigger_pkg.sv
// Shared types and constants for the ADC trigger path, fill stage and VGA reader.
package adc_trigger_pkg;

    localparam int ADC_W     = 8;
    localparam int FRAME_LEN = 160;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLDOFF
    } trig_state_t;

endpackage

// File: rtl/trig_compare.sv
// Level-crossing detector with hysteresis; 9-bit sums so threshold +/- HYST never wraps.
module trig_compare
    import adc_trigger_pkg::*;
#(
    parameter int unsigned HYST = 4
) (
    input  logic [ADC_W-1:0] adc_q,
    input  logic [ADC_W-1:0] lvl_l,
    input  logic             slope_l,
    output logic             arm_hit,
    output logic             fire_hit
);

    localparam int SUM_W = ADC_W + 1;
    localparam logic [SUM_W-1:0] HYST_X = SUM_W'(HYST);

    logic [SUM_W-1:0] adc_x;
    logic [SUM_W-1:0] lvl_x;

    assign adc_x = {1'b0, adc_q};
    assign lvl_x = {1'b0, lvl_l};

    always_comb begin
        if (slope_l == SLOPE_RISE) begin
            arm_hit  = (adc_x + HYST_X) < lvl_x;
            fire_hit = adc_q >= lvl_l;
        end else begin
            arm_hit  = adc_x > (lvl_x + HYST_X);
            fire_hit = adc_q <= lvl_l;
        end
    end

endmodule

// File: rtl/adc_trigger.sv
// Trigger/capture sequencer feeding the 160-sample fill stage.
//   state   | meaning
//   IDLE    | no acquisition requested
//   ARM     | waiting for the signal to leave the hysteresis band
//   WAIT    | armed, waiting for the level crossing
//   CAPTURE | enable high until the fill stage reports finished
//   HOLDOFF | fixed dead time before re-arming
module adc_trigger
    import adc_trigger_pkg::*;
#(
    parameter int unsigned HYST           = 4,
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned AUTO_TIMEOUT   = 65535
) (
    input  logic             clk_adc,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [ADC_W-1:0] trig_level,
    input  logic             trig_slope,
    input  logic             run,
    input  logic             single,
    input  logic             auto_mode,
    input  logic             finished,
    output logic             enable,
    output logic             triggered,
    output logic             auto_fired,
    output logic             frame_done,
    output logic             busy
);

    localparam int TMO_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
    localparam int HLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(AUTO_TIMEOUT - 1);
    localparam logic [HLD_W-1:0] HLD_LOAD = HLD_W'(HOLDOFF_CYCLES - 1);

    trig_state_t      state_q, state_d;
    logic [ADC_W-1:0] adc_q, adc_d;
    logic [ADC_W-1:0] lvl_q, lvl_d;
    logic             slope_q, slope_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic             oneshot_q, oneshot_d;
    logic             enable_q, enable_d;
    logic             triggered_q, triggered_d;
    logic             auto_fired_q, auto_fired_d;
    logic             frame_done_q, frame_done_d;
    logic             busy_q, busy_d;

    logic arm_hit, fire_hit, tmo_hit, run_lost;

    trig_compare #(.HYST(HYST)) u_cmp (
        .adc_q    (adc_q),
        .lvl_l    (lvl_q),
        .slope_l  (slope_q),
        .arm_hit  (arm_hit),
        .fire_hit (fire_hit)
    );

    assign tmo_hit  = auto_mode && (tmo_q == TMO_LAST);
    assign run_lost = !run && !oneshot_q;

    always_comb begin
        state_d      = state_q;
        adc_d        = adc_data;
        lvl_d        = lvl_q;
        slope_d      = slope_q;
        tmo_d        = tmo_q;
        hold_d       = hold_q;
        oneshot_d    = oneshot_q;
        auto_fired_d = auto_fired_q;

        case (state_q)
            ST_IDLE: begin
                if (run || single) begin
                    state_d   = ST_ARM;
                    oneshot_d = !run;
                end
            end
            ST_ARM: begin
                if (run_lost) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    state_d      = ST_CAPTURE;
                    auto_fired_d = 1'b1;
                end else if (arm_hit) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A genuine crossing outranks a coincident timeout.
                if (run_lost) begin
                    state_d = ST_IDLE;
                end else if (fire_hit) begin
                    state_d      = ST_CAPTURE;
                    auto_fired_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d      = ST_CAPTURE;
                    auto_fired_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (finished) begin
                    state_d = ST_HOLDOFF;
                    hold_d  = HLD_LOAD;
                end
            end
            ST_HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = (run && !oneshot_q) ? ST_ARM : ST_IDLE;
                end else begin
                    hold_d = hold_q - HLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ARM && state_q != ST_ARM) begin
            lvl_d   = trig_level;
            slope_d = trig_slope;
            tmo_d   = '0;
        end else if ((state_q == ST_ARM || state_q == ST_WAIT) && tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        enable_d     = (state_d == ST_CAPTURE);
        triggered_d  = (state_d == ST_CAPTURE) && (state_q != ST_CAPTURE);
        frame_done_d = (state_d == ST_HOLDOFF) && (state_q == ST_CAPTURE);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            adc_q        <= '0;
            lvl_q        <= '0;
            slope_q      <= 1'b0;
            tmo_q        <= '0;
            hold_q       <= '0;
            oneshot_q    <= 1'b0;
            enable_q     <= 1'b0;
            triggered_q  <= 1'b0;
            auto_fired_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            adc_q        <= adc_d;
            lvl_q        <= lvl_d;
            slope_q      <= slope_d;
            tmo_q        <= tmo_d;
            hold_q       <= hold_d;
            oneshot_q    <= oneshot_d;
            enable_q     <= enable_d;
            triggered_q  <= triggered_d;
            auto_fired_q <= auto_fired_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign enable     = enable_q;
    assign triggered  = triggered_q;
    assign auto_fired = auto_fired_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_adc_trigger.sv
// Scoreboard bench for adc_trigger: stimulus queues expected trigger/frame-done events,
// a negedge monitor pops and compares them when the DUT pulses.
module tb_adc_trigger;
    import adc_trigger_pkg::*;

    localparam int HOLD = 1024;

    typedef struct {
        int   kind;
        int   cyc;
        logic af;
    } exp_t;

    logic       clk_adc = 1'b0;
    logic       reset;
    logic [7:0] adc_data;
    logic [7:0] trig_level;
    logic       trig_slope;
    logic       run;
    logic       single;
    logic       auto_mode;
    logic       finished;
    logic       enable;
    logic       triggered;
    logic       auto_fired;
    logic       frame_done;
    logic       busy;

    int   cyc       = 0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   en_cnt    = 0;
    int   trig_seen = 0;
    exp_t sb_q[$];
    logic [7:0] fill_cnt;

    adc_trigger #(
        .HYST           (4),
        .HOLDOFF_CYCLES (HOLD),
        .AUTO_TIMEOUT   (100)
    ) dut (
        .clk_adc    (clk_adc),
        .reset      (reset),
        .adc_data   (adc_data),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .run        (run),
        .single     (single),
        .auto_mode  (auto_mode),
        .finished   (finished),
        .enable     (enable),
        .triggered  (triggered),
        .auto_fired (auto_fired),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk_adc = ~clk_adc;

    always @(posedge clk_adc) cyc <= cyc + 1;

    // Fill stage model: counts enabled cycles, flags the last sample of the frame.
    always @(posedge clk_adc or posedge reset) begin
        if (reset)       fill_cnt <= 8'd0;
        else if (enable) fill_cnt <= fill_cnt + 8'd1;
        else             fill_cnt <= 8'd0;
    end
    assign finished = enable && (fill_cnt == 8'(FRAME_LEN - 1));

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_evt(input int kind);
        exp_t  e;
        string nm;
        nm = (kind == 0) ? "trig" : "done";
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_unexpected: got event at cycle %0d, required none", nm, cyc);
        end else begin
            e = sb_q.pop_front();
            check({nm, "_kind"}, kind, e.kind);
            check({nm, "_cycle"}, cyc, e.cyc);
            check({nm, "_auto_fired"}, int'(auto_fired), int'(e.af));
        end
    endtask

    always @(negedge clk_adc) begin
        if (reset) begin
            en_cnt = 0;
        end else begin
            if (enable) en_cnt++;
            if (triggered) begin
                trig_seen++;
                check_evt(0);
            end
            if (frame_done) begin
                check_evt(1);
                check("enable_cycles", en_cnt, FRAME_LEN);
                en_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_adc);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk_adc);
    endtask

    task automatic expect_frame(input int t, input logic af);
        sb_q.push_back(exp_t'{kind: 0, cyc: t, af: af});
        sb_q.push_back(exp_t'{kind: 1, cyc: t + FRAME_LEN, af: af});
    endtask

    // Frame triggered at cycle t, run already dropped: IDLE exactly HOLD cycles after frame_done.
    task automatic drain(input int t);
        at_cyc(t + FRAME_LEN + HOLD - 1);
        check("busy_last_holdoff", int'(busy), 1);
        step(1);
        check("busy_back_idle", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int t, f, a;
        reset = 1'b1; adc_data = 8'd0; trig_level = 8'd0; trig_slope = 1'b0;
        run = 1'b0; single = 1'b0; auto_mode = 1'b0;
        step(3);
        check("rst_enable", int'(enable), 0);
        check("rst_triggered", int'(triggered), 0);
        check("rst_auto_fired", int'(auto_fired), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        step(2);
        check("idle_busy", int'(busy), 0);

        // Rising ramp, then re-arm timing pinned by the level latched at ARM entry.
        trig_level = 8'd128; trig_slope = SLOPE_RISE; adc_data = 8'd100; run = 1'b1;
        t = 0;
        for (int v = 101; v <= 200; v++) begin
            step(1);
            adc_data = 8'(v);
            if (v == 128) begin
                t = cyc + 2;
                expect_frame(t, 1'b0);
            end
        end
        adc_data = 8'd100; trig_level = 8'd250;
        f = t + FRAME_LEN;
        at_cyc(f + 5);
        check("busy_in_holdoff", int'(busy), 1);
        at_cyc(f + HOLD - 1);
        trig_level = 8'd128;
        step(1);
        adc_data = 8'd200;
        t = cyc + 2;
        expect_frame(t, 1'b0);
        at_cyc(t + 5);
        run = 1'b0;
        drain(t);

        // Falling slope: noise inside the band must not arm.
        trig_slope = SLOPE_FALL; trig_level = 8'd128; adc_data = 8'd126; run = 1'b1;
        a = trig_seen;
        for (int i = 0; i < 40; i++) begin
            step(1);
            adc_data = (i % 2 == 0) ? 8'd130 : 8'd126;
        end
        step(3);
        check("noise_no_fire", trig_seen, a);
        adc_data = 8'd140; step(1);
        adc_data = 8'd130; step(1);
        adc_data = 8'd127;
        t = cyc + 2;
        expect_frame(t, 1'b0);
        at_cyc(t + 5);
        run = 1'b0;
        drain(t);

        // Auto capture on timeout, then a real fire coincident with the timeout.
        trig_slope = SLOPE_RISE; trig_level = 8'd128; adc_data = 8'd50;
        auto_mode = 1'b1; run = 1'b1;
        t = cyc + 101;
        expect_frame(t, 1'b1);
        at_cyc(t + FRAME_LEN + 5);
        check("auto_fired_holdoff", int'(auto_fired), 1);
        a = t + FRAME_LEN + HOLD;
        at_cyc(a + 98);
        adc_data = 8'd200;
        t = cyc + 2;
        expect_frame(t, 1'b0);
        at_cyc(t + 5);
        run = 1'b0; auto_mode = 1'b0; adc_data = 8'd50;
        drain(t);
        check("auto_fired_after_real", int'(auto_fired), 0);

        // Single shot with run low; a second single during HOLDOFF is ignored.
        trig_level = 8'd128; adc_data = 8'd100; single = 1'b1;
        step(1);
        single = 1'b0;
        step(3);
        adc_data = 8'd150;
        t = cyc + 2;
        expect_frame(t, 1'b0);
        at_cyc(t + FRAME_LEN + 10);
        single = 1'b1;
        step(1);
        single = 1'b0;
        drain(t);
        step(50);
        check("single_stays_idle", int'(busy), 0);

        // Level change mid-frame takes effect only at the next ARM entry.
        run = 1'b1; trig_level = 8'd128; adc_data = 8'd100;
        step(3);
        adc_data = 8'd150;
        t = cyc + 2;
        expect_frame(t, 1'b0);
        at_cyc(t + 20);
        trig_level = 8'd60; adc_data = 8'd100;
        a = t + FRAME_LEN + HOLD;
        at_cyc(a + 20);
        adc_data = 8'd150;
        step(10);
        adc_data = 8'd40;
        step(1);
        adc_data = 8'd70;
        t = cyc + 2;
        expect_frame(t, 1'b0);

        // Asynchronous reset at enable cycle 80 of that frame.
        at_cyc(t + 79);
        check("enable_before_reset", int'(enable), 1);
        check("pending_events", sb_q.size(), 1);
        reset = 1'b1; run = 1'b0;
        #1;
        check("async_rst_enable", int'(enable), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_triggered", int'(triggered), 0);
        sb_q.delete();
        step(3);
        reset = 1'b0;
        step(10);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_enable", int'(enable), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_trigger.md
# adc_trigger

Trigger and capture controller directly upstream of the 160-sample fill stage. Watches the raw ADC stream for a level crossing with hysteresis, then raises `enable` so the fill stage counts exactly one 160-sample frame. It drops `enable` when the fill stage reports `finished`, then waits a hold-off period before re-arming. It supports continuous, single-shot and auto (free-run on timeout) acquisition for the VGA scope display.

## Interface
- `HYST`, default 4: hysteresis band in ADC codes, range 0–255.
- `HOLDOFF_CYCLES`, default 1024: cycles spent in HOLDOFF, minimum 1.
- `AUTO_TIMEOUT`, default 65535: cycles in ARM+WAIT before an auto capture, minimum 1.
- `clk_adc`  in  1  ADC sample clock, the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `adc_data`  in  8  raw ADC sample, unsigned.
- `trig_level`  in  8  trigger threshold.
- `trig_slope`  in  1  0 selects rising edge, 1 selects falling edge.
- `run`  in  1  continuous acquisition when high.
- `single`  in  1  one-cycle request for one capture; honoured only in IDLE.
- `auto_mode`  in  1  enables the timeout-forced capture.
- `finished`  in  1  end-of-frame flag from the fill stage.
- `enable`  out  1  count/write enable to the fill stage.
- `triggered`  out  1  one-cycle pulse on entry to CAPTURE.
- `auto_fired`  out  1  high if the current or last frame was forced by timeout.
- `frame_done`  out  1  one-cycle pulse on CAPTURE→HOLDOFF.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `adc_q` registers `adc_data` every cycle. All comparisons use `adc_q` and the latched `lvl_l`/`slope_l`, with 9-bit sums and no wrap.
- `lvl_l` and `slope_l` latch `trig_level` and `trig_slope` on every entry to ARM. They stay constant through WAIT, CAPTURE and HOLDOFF.
- Rising slope: arm when `adc_q + HYST < lvl_l`; fire when `adc_q >= lvl_l`. If `lvl_l <= HYST` the block never arms, so only an auto capture is possible.
- Falling slope: arm when `adc_q > lvl_l + HYST`; fire when `adc_q <= lvl_l`.
- State machine:
  - IDLE → ARM when `run` or `single` is high. The request source is recorded as `oneshot = !run`.
  - ARM → WAIT when the arm condition holds.
  - WAIT → CAPTURE when the fire condition holds.
  - CAPTURE → HOLDOFF on the first cycle `finished` = 1.
  - HOLDOFF → ARM after `HOLDOFF_CYCLES` cycles if `run` is high and `oneshot` is clear. Otherwise HOLDOFF → IDLE.
- Auto capture: `tmo_cnt` clears on entry to ARM and counts cycles spent in ARM+WAIT. When `auto_mode` = 1 and `tmo_cnt == AUTO_TIMEOUT-1`, the block goes to CAPTURE and sets `auto_fired`.
- If a real fire and the timeout occur in the same cycle, the real trigger wins and `auto_fired` = 0.
- `auto_fired` updates only on entry to CAPTURE.
- `finished` is ignored outside CAPTURE.
- `single` outside IDLE is ignored.
- Dropping `run` during ARM or WAIT returns to IDLE next cycle. Dropping it during CAPTURE or HOLDOFF lets the frame and hold-off complete, then the block goes to IDLE.
- Reset values: state IDLE, all outputs 0, `adc_q` 0, `lvl_l` 0, `slope_l` 0, both counters 0. An asserted reset forces `enable` low immediately, mid-capture included.

## Timing
- `enable`, `triggered`, `frame_done` and `busy` are registered outputs, decoded from the next state.
- Trigger latency:
  - Crossing sample is present on `adc_data` at edge N.
  - It is compared in `adc_q` during cycle N.
  - `enable` and `triggered` rise after edge N+1.
  - The fill stage's first counted sample is taken at edge N+2.
- `enable` is high for exactly the cycles between the CAPTURE entry edge and the edge on which `finished` is sampled high. That is 160 enable cycles when the fill counter starts at 0.
- `frame_done` is high in the cycle after `finished` was sampled, coincident with the first HOLDOFF cycle.
- Minimum re-arm gap is `HOLDOFF_CYCLES` + 1 cycles.

## Structure
- Shared package holds:
  - state encoding enum: IDLE, ARM, WAIT, CAPTURE, HOLDOFF;
  - slope constants SLOPE_RISE = 0 and SLOPE_FALL = 1;
  - ADC_W = 8 and FRAME_LEN = 160, also used by the fill stage and the VGA reader.
- One sub-module, `trig_compare`, is natural. It is combinational and produces `arm_hit`/`fire_hit` from `adc_q`, `lvl_l`, `slope_l` and `HYST`.

## Test plan
- Rising trigger: HYST=4, level=128, `run`=1, ramp 100→200. `triggered` pulses 2 cycles after the first sample ≥128. `enable` stays high until the model `finished` rises 160 cycles later. `frame_done` pulses, and re-arm occurs 1024 cycles later.
- Falling trigger with noise: sample toggles 126/130 around level 128 with no excursion above 132. The block never fires. After one excursion to 140 and a drop to 127, it fires once.
- Auto mode: AUTO_TIMEOUT=100, constant input 50, level=128, `auto_mode`=1. CAPTURE begins 100 cycles after ARM entry with `auto_fired`=1. A coincident real fire yields `auto_fired`=0.
- Single shot: `run`=0, one `single` pulse, valid crossing. Exactly one frame is captured, then IDLE with `busy`=0. A second `single` during HOLDOFF is ignored.
- Reset mid-capture: assert `reset` at enable cycle 80. `enable`, `busy` and `triggered` are 0 without waiting for a clock. After release the block sits in IDLE.
- Level change mid-frame: change `trig_level` 128→60 during CAPTURE. The current frame is unaffected, and the new level takes effect at the next ARM entry.
